// File: rtl/beat_pkg.sv
// Shared beatmap timing definitions: scheduler state encoding, lane count and
// the default frame/scroll constants also used by the renderer.
package beat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNTIN = 3'd1,
    ST_PLAY    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } beat_state_e;

  localparam int LANES                  = 4;
  localparam int DEFAULT_FRAME_DIV      = 833333;
  localparam int DEFAULT_FRAMES_PER_ROW = 7;

  function automatic logic is_active(input beat_state_e s);
    return (s == ST_COUNTIN) || (s == ST_PLAY) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one-cycle registered tick on the cycle after the
// counter reaches FRAME_DIV-1.
module frame_tick_gen
  import beat_pkg::*;
#(
  parameter int FRAME_DIV = DEFAULT_FRAME_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(FRAME_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(FRAME_DIV - 1));
      if (cnt == CW'(FRAME_DIV - 1)) cnt <= '0;
      else                            cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/beat_scheduler.sv
// Beatmap playback sequencer: frame timebase, row scroll phase, note ROM fetch
// and song lifecycle. Optional playback hold is built when BEAT_SCHED_PAUSE_EN is defined.
module beat_scheduler
  import beat_pkg::*;
#(
  parameter int FRAME_DIV      = DEFAULT_FRAME_DIV,
  parameter int FRAMES_PER_ROW = DEFAULT_FRAMES_PER_ROW,
  parameter int SONG_LEN       = 8192,
  parameter int ADDR_W         = 13,
  parameter int COUNTIN_ROWS   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [LANES-1:0]  rom_data,
  output logic              frame_tick,
  output logic              row_advance,
  output logic [LANES-1:0]  row_note,
  output logic [2:0]        scroll_phase,
  output logic              playing,
  output logic              done,
  output logic [2:0]        state_dbg
);

  localparam int RW = $clog2(COUNTIN_ROWS + 1);

  beat_state_e       state, state_d;
  logic [RW-1:0]     row_cnt, row_cnt_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [LANES-1:0]  row_note_d;
  logic [2:0]        phase_d;
  logic              adv_d;
  logic              hold;
  logic              last_row;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (frame_tick)
  );

`ifdef BEAT_SCHED_PAUSE_EN
  assign hold = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold         = 1'b0;
`endif

  assign last_row  = (row_cnt == RW'(COUNTIN_ROWS - 1));
  assign state_dbg = state;

  always_comb begin
    state_d    = state;
    row_cnt_d  = row_cnt;
    rom_addr_d = rom_addr;
    row_note_d = row_note;
    phase_d    = scroll_phase;
    adv_d      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_COUNTIN;
          row_cnt_d  = '0;
          rom_addr_d = '0;
          row_note_d = '0;
          phase_d    = '0;
        end
      end
      ST_COUNTIN, ST_PLAY, ST_DRAIN: begin
        if (frame_tick && !hold) begin
          if (scroll_phase == 3'(FRAMES_PER_ROW - 1)) begin
            phase_d = '0;
            adv_d   = 1'b1;
            // PLAY consumes the prefetched word; count-in/drain rows are blank.
            if (state == ST_PLAY) begin
              row_note_d = rom_data;
              if (rom_addr == ADDR_W'(SONG_LEN - 1)) state_d = ST_DRAIN;
              else rom_addr_d = rom_addr + ADDR_W'(1);
            end else begin
              row_note_d = '0;
              if (last_row) begin
                row_cnt_d = '0;
                state_d   = (state == ST_COUNTIN) ? ST_PLAY : ST_DONE;
              end else begin
                row_cnt_d = row_cnt + RW'(1);
              end
            end
          end else begin
            phase_d = scroll_phase + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      row_cnt      <= '0;
      rom_addr     <= '0;
      row_note     <= '0;
      scroll_phase <= '0;
      row_advance  <= 1'b0;
      playing      <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      row_cnt      <= row_cnt_d;
      rom_addr     <= rom_addr_d;
      row_note     <= row_note_d;
      scroll_phase <= phase_d;
      row_advance  <= adv_d;
      playing      <= is_active(state_d);
      done         <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_beat_scheduler.sv
// Bench for beat_scheduler: cycle table for reset/idle/start, then scoreboarded
// song runs covering held start, mid-song reset and playback hold.
module tb_beat_scheduler;

  localparam int FD = 4;
  localparam int FPR = 3;
  localparam int SL = 4;
  localparam int CR = 2;
  localparam int AW = 2;
`ifdef BEAT_SCHED_PAUSE_EN
  localparam int PAUSE_GAP = 32;
`else
  localparam int PAUSE_GAP = 12;
`endif

  logic          clk = 1'b0;
  logic          reset, start, pause;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_data;
  logic          frame_tick, row_advance, playing, done;
  logic [3:0]    row_note;
  logic [2:0]    scroll_phase, state_dbg;

  logic [3:0] rom [0:SL-1] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [3:0] exp_q[$];

  int total = 0, bad = 0;
  int n_adv = 0, cyc = 0, last_cyc = -1, first_adv_cyc = -1, gap_exp = 12;
  logic prev_adv = 1'b0;

  typedef struct {
    logic rst;
    logic start;
    int   tick;
    int   adv;
    int   phase;
    int   playing;
    int   done;
    int   addr;
    int   note;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  beat_scheduler #(
    .FRAME_DIV(FD), .FRAMES_PER_ROW(FPR), .SONG_LEN(SL), .ADDR_W(AW), .COUNTIN_ROWS(CR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pause        (pause),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .frame_tick   (frame_tick),
    .row_advance  (row_advance),
    .row_note     (row_note),
    .scroll_phase (scroll_phase),
    .playing      (playing),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input int t, input int a,
                              input int ph, input int pl, input int d, input int ad,
                              input int n);
    vec_t v;
    v.rst = r; v.start = s; v.tick = t; v.adv = a; v.phase = ph;
    v.playing = pl; v.done = d; v.addr = ad; v.note = n;
    return v;
  endfunction

  task automatic push_song();
    for (int i = 0; i < CR; i++) exp_q.push_back(4'h0);
    for (int i = 0; i < SL; i++) exp_q.push_back(rom[i]);
    for (int i = 0; i < CR; i++) exp_q.push_back(4'h0);
  endtask

  // One clock: sample #1 after the edge, score any strobe against the queue.
  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (row_advance) begin
      n_adv++;
      check("adv_back_to_back", int'(prev_adv), 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe_unexpected: got row_note=%0h, required no strobe (cycle %0d)",
                 row_note, cyc);
      end else begin
        e = exp_q.pop_front();
        check("row_note", int'(row_note), int'(e));
      end
      if (last_cyc < 0) first_adv_cyc = cyc;
      else if (gap_exp != 0) check("strobe_gap", cyc - last_cyc, gap_exp);
      last_cyc = cyc;
    end
    if (!playing) last_cyc = -1;
    prev_adv = row_advance;
  endtask

  task automatic wait_adv(input int target, input int budget);
    int n;
    n = 0;
    while (n_adv < target && n < budget) begin
      step();
      n++;
    end
    check("strobe_wait", n_adv, target);
  endtask

  initial begin
    int start_cyc, base, n, ticks;
    vec_t v;
    start_cyc = 0;

    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);

    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    repeat (3) step();
    check("reset_state", int'(state_dbg), 0);

    // Reset, idle ticking and start, cycle by cycle.
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      reset = v.rst;
      start = v.start;
      if (v.start) push_song();
      step();
      if (v.start) start_cyc = cyc;
      check($sformatf("vec%0d_tick", i), int'(frame_tick), v.tick);
      check($sformatf("vec%0d_adv", i), int'(row_advance), v.adv);
      check($sformatf("vec%0d_phase", i), int'(scroll_phase), v.phase);
      check($sformatf("vec%0d_playing", i), int'(playing), v.playing);
      check($sformatf("vec%0d_done", i), int'(done), v.done);
      check($sformatf("vec%0d_addr", i), int'(rom_addr), v.addr);
      check($sformatf("vec%0d_note", i), int'(row_note), v.note);
    end
    start = 1'b0;

    // Full song from a single start pulse.
    wait_adv(CR + SL + CR, 200);
    check("song1_first_latency", first_adv_cyc - start_cyc, FPR * FD);
    check("song1_done", int'(done), 1);
    check("song1_playing", int'(playing), 0);
    check("song1_addr", int'(rom_addr), SL - 1);
    check("song1_note", int'(row_note), 0);
    check("song1_state", int'(state_dbg), 4);
    check("song1_queue_left", exp_q.size(), 0);
    repeat (3) step();
    check("done_hold", int'(done), 1);
    check("done_phase", int'(scroll_phase), 0);

    // Start held through the whole song: one song, then immediate restart.
    start = 1'b1;
    push_song();
    base = n_adv;
    step();
    check("held_playing", int'(playing), 1);
    n = 0;
    while (!done && n < 300) begin
      step();
      n++;
    end
    check("held_done_seen", int'(done), 1);
    check("held_strobes", n_adv - base, CR + SL + CR);
    step();
    check("restart_playing", int'(playing), 1);
    check("restart_done", int'(done), 0);
    start = 1'b0;

    // Mid-song reset between the 4th and 5th strobe.
    for (int i = 0; i < CR; i++) exp_q.push_back(4'h0);
    for (int i = 0; i < 2; i++) exp_q.push_back(rom[i]);
    base = n_adv;
    wait_adv(base + 4, 200);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_playing", int'(playing), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(rom_addr), 0);
    check("rst_note", int'(row_note), 0);
    check("rst_adv", int'(row_advance), 0);
    check("rst_state", int'(state_dbg), 0);
    repeat (40) step();
    check("rst_no_more_strobes", n_adv, base + 4);
    check("rst_idle_phase", int'(scroll_phase), 0);

    // Hold playback for 20 cycles right after the first PLAY row.
    start = 1'b1;
    push_song();
    step();
    start = 1'b0;
    base = n_adv - 0;
    base = base + 0;
    wait_adv(base + CR + 1, 200);
    pause = 1'b1;
    gap_exp = PAUSE_GAP;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ticks += int'(frame_tick);
    end
    pause = 1'b0;
    check("pause_ticks", ticks, 5);
`ifdef BEAT_SCHED_PAUSE_EN
    check("pause_phase_frozen", int'(scroll_phase), 0);
    check("pause_no_strobe", n_adv, base + CR + 1);
`else
    check("pause_ignored_strobe", n_adv, base + CR + 2);
`endif
    wait_adv(base + CR + 2, 100);
    gap_exp = 12;
    wait_adv(base + CR + SL + CR, 300);
    check("pause_song_done", int'(done), 1);
    check("pause_queue_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
